// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
//
// Sequences a five-stage MIPS pipeline around the ID/EX register. It detects
// load-use hazards, data-memory wait states and taken branches. From these it
// drives the load/bubble/clear controls of the PC and the pipeline registers.
// It also selects ID-stage operand forwarding sources and keeps saturating
// stall and flush performance counters.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   id_rs/rt, uses_*    source registers of the ID instruction and whether read
//   ex_*, mem_*, wb_*   destination / write / load flags of younger producers
//   mem_req, mem_ready  data memory handshake of the MEM stage
//   branch_taken        taken branch or jump resolved in ID
//   perf_clr            synchronous clear of the performance counters
//   pc_ld .. memwb_bubble  pipeline register controls (Mealy)
//   fwd_a_sel/fwd_b_sel 00 regfile, 01 EX, 10 MEM, 11 WB
//   state               00 RUN, 01 LOAD_STALL, 10 MEM_WAIT
//   stall_cnt/flush_cnt saturating performance counters
module pipeline_hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_dest,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_dest,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [4:0]       wb_dest,
  input  logic             wb_reg_write,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             branch_taken,
  input  logic             perf_clr,
  output logic             pc_ld,
  output logic             ifid_ld,
  output logic             ifid_clr,
  output logic             idex_ld,
  output logic             idex_bubble,
  output logic             exmem_ld,
  output logic             memwb_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] ST_RUN        = 2'b00;
  localparam logic [1:0] ST_LOAD_STALL = 2'b01;
  localparam logic [1:0] ST_MEM_WAIT   = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [1:0]       ret_state_q, ret_state_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic       ld_ex, ld_mem, mem_wait;
  logic [1:0] eff_state;
  logic [1:0] fwd_a, fwd_b;

  // A producer hazards an ID source when it writes a non-zero register equal
  // to a source the ID instruction actually reads.
  function automatic logic haz(input logic uses, input logic [4:0] src,
                               input logic wr, input logic [4:0] dst);
    return uses & wr & (dst != 5'd0) & (dst == src);
  endfunction

  // Youngest non-load producer wins. Loads in EX/MEM cannot forward yet, so
  // they fall through to older stages; the stall logic covers that case.
  function automatic logic [1:0] fwd_sel(input logic uses, input logic [4:0] src,
                                         input logic [4:0] exd, input logic exw,
                                         input logic exl, input logic [4:0] memd,
                                         input logic memw, input logic meml,
                                         input logic [4:0] wbd, input logic wbw);
    if (haz(uses, src, exw, exd) && !exl)         return 2'b01;
    else if (haz(uses, src, memw, memd) && !meml) return 2'b10;
    else if (haz(uses, src, wbw, wbd))            return 2'b11;
    else                                          return 2'b00;
  endfunction

  // Hazard terms for the current ID instruction.
  always_comb begin
    ld_ex  = ex_mem_read & (haz(id_uses_rs, id_rs, ex_reg_write, ex_dest) |
                            haz(id_uses_rt, id_rt, ex_reg_write, ex_dest));
    ld_mem = mem_mem_read & (haz(id_uses_rs, id_rs, mem_reg_write, mem_dest) |
                             haz(id_uses_rt, id_rt, mem_reg_write, mem_dest));
    mem_wait = mem_req & ~mem_ready;
    fwd_a = fwd_sel(id_uses_rs, id_rs, ex_dest, ex_reg_write, ex_mem_read,
                    mem_dest, mem_reg_write, mem_mem_read, wb_dest, wb_reg_write);
    fwd_b = fwd_sel(id_uses_rt, id_rt, ex_dest, ex_reg_write, ex_mem_read,
                    mem_dest, mem_reg_write, mem_mem_read, wb_dest, wb_reg_write);
  end

  // Mealy control and next-state logic. The release cycle of MEM_WAIT is
  // handled by evaluating the hazards as if still in the saved return state.
  always_comb begin
    state_d      = state_q;
    ret_state_d  = ret_state_q;
    pc_ld        = 1'b1;
    ifid_ld      = 1'b1;
    ifid_clr     = 1'b0;
    idex_ld      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_ld     = 1'b1;
    memwb_bubble = 1'b0;
    fwd_a_sel    = fwd_a;
    fwd_b_sel    = fwd_b;
    eff_state    = (state_q == ST_MEM_WAIT) ? ret_state_q : state_q;

    if (!reset) begin
      pc_ld        = 1'b0;
      ifid_ld      = 1'b0;
      idex_ld      = 1'b0;
      exmem_ld     = 1'b0;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
      fwd_a_sel    = 2'b00;
      fwd_b_sel    = 2'b00;
      state_d      = ST_RUN;
      ret_state_d  = ST_RUN;
    end else if ((state_q == ST_MEM_WAIT && !mem_ready) || mem_wait) begin
      // Freeze: nothing advances, MEM/WB receives a bubble.
      pc_ld        = 1'b0;
      ifid_ld      = 1'b0;
      idex_ld      = 1'b0;
      exmem_ld     = 1'b0;
      memwb_bubble = 1'b1;
      if (state_q != ST_MEM_WAIT) begin
        ret_state_d = eff_state;
        state_d     = ST_MEM_WAIT;
      end
    end else if (eff_state == ST_LOAD_STALL || ld_ex || ld_mem) begin
      // Load-use stall: hold PC and IF/ID, insert a bubble into ID/EX.
      pc_ld       = 1'b0;
      ifid_ld     = 1'b0;
      idex_bubble = 1'b1;
      state_d     = (eff_state != ST_LOAD_STALL && ld_ex) ? ST_LOAD_STALL : ST_RUN;
    end else begin
      ifid_clr = branch_taken;
      state_d  = ST_RUN;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      ret_state_q <= ST_RUN;
    end else begin
      state_q     <= state_d;
      ret_state_q <= ret_state_d;
    end
  end

  // Saturating performance counters; clear beats increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (perf_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_ld && stall_cnt_q != CNT_MAX) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (ifid_clr && flush_cnt_q != CNT_MAX) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the five-stage MIPS pipeline around the ID/EX register.
- Detects load-use hazards, memory wait states and taken branches.
- Drives the stall, bubble, hold and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Generates ID-stage operand forwarding selects for PA/PB and keeps saturating stall/flush performance counters.

Parameters:
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low; asserted when 0
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_dest  in  5  destination register in EX
ex_reg_write  in  1  EX instruction writes the register file
ex_mem_read  in  1  EX instruction is a load
mem_dest  in  5  destination register in MEM
mem_reg_write  in  1  MEM instruction writes the register file
mem_mem_read  in  1  MEM instruction is a load
wb_dest  in  5  destination register in WB
wb_reg_write  in  1  WB instruction writes the register file
mem_req  in  1  MEM stage is accessing data memory
mem_ready  in  1  data memory completes the access this cycle
branch_taken  in  1  taken branch or jump resolved in ID
perf_clr  in  1  synchronous clear of the counters
pc_ld  out  1  PC load enable
ifid_ld  out  1  IF/ID load enable
ifid_clr  out  1  IF/ID clears to NOP
idex_ld  out  1  ID/EX load enable
idex_bubble  out  1  ID/EX captures all-zero control signals (25 bits)
exmem_ld  out  1  EX/MEM load enable
memwb_bubble  out  1  MEM/WB captures zero control signals
fwd_a_sel  out  2  PA source: 00 regfile, 01 EX, 10 MEM, 11 WB
fwd_b_sel  out  2  PB source, same encoding
state  out  2  00 RUN, 01 LOAD_STALL, 10 MEM_WAIT
stall_cnt  out  CNT_W  saturating count of stalled cycles
flush_cnt  out  CNT_W  saturating count of flushes

Behaviour:
- Reset (reset=0, async):
  - state=RUN, ret_state=RUN, counters 0.
  - While asserted: pc_ld=ifid_ld=idex_ld=exmem_ld=0, idex_bubble=memwb_bubble=1, ifid_clr=0, fwd selects 00.
- Control outputs are Mealy: a function of the registered state and the current inputs. State and counters update on posedge clk.
- Hazard terms:
  - hazRS(x) = id_uses_rs & x_reg_write & x_dest!=0 & x_dest==id_rs.
  - hazRT(x) is the same using rt.
  - ldEX = ex_mem_read & (hazRS(ex)|hazRT(ex)).
  - ldMEM = mem_mem_read & (hazRS(mem)|hazRT(mem)).
  - wait = mem_req & ~mem_ready.
- Priority each cycle: wait > load stall > branch.
- RUN:
  - wait: freeze. All *_ld=0, memwb_bubble=1, idex_bubble=0. ret_state<=RUN, go to MEM_WAIT.
  - else ldEX: pc_ld=ifid_ld=0, idex_ld=1, idex_bubble=1. Go to LOAD_STALL.
  - else ldMEM: same stall for this cycle only; stay in RUN.
  - else branch_taken: all loads=1, ifid_clr=1 (squashes the fall-through fetch; there is no delay slot). flush_cnt+1.
  - else: all loads=1, no bubbles.
- LOAD_STALL (the load is now in MEM):
  - wait: freeze as above, ret_state<=LOAD_STALL, go to MEM_WAIT.
  - else: stall again (pc_ld=ifid_ld=0, idex_bubble=1). Go to RUN.
  - branch_taken is ignored.
- MEM_WAIT:
  - Freeze while mem_ready=0.
  - On mem_ready=1: this cycle behaves as the freeze release (all *_ld=1, memwb_bubble=0, hazards evaluated as in ret_state). Next state is derived as in ret_state.
- branch_taken is ignored in any cycle where a stall or freeze is asserted.
- Forwarding, per operand:
  - Source register 0 → 00.
  - Else EX match with ~ex_mem_read → 01.
  - Else MEM match with ~mem_mem_read → 10.
  - Else WB match → 11.
  - Else 00. The youngest producer wins.
  - Selects are don't-care during a stall, but must still follow these rules.
- Counters:
  - stall_cnt +1 on every cycle with pc_ld=0 (excluding reset). flush_cnt +1 per ifid_clr.
  - Both saturate at all-ones.
  - perf_clr has priority over increment.
- Reset asserted mid-stall or mid-wait returns to RUN immediately. No pending branch is retained.

Test Plan:
- LW r5 in EX, ID ADD uses rs=5 → two cycles pc_ld=0/idex_bubble=1 (RUN→LOAD_STALL→RUN); third cycle fwd_a_sel=11.
- LW r5 in MEM, ID uses rt=5, nothing in EX → exactly one stall cycle, state stays RUN; next cycle fwd_b_sel=11.
- ADD r3 in EX and ADD r3 in MEM, ID uses rs=3 → fwd_a_sel=01; ID uses r0 with ex_dest=0 → 00, no stall.
- mem_req=1, mem_ready=0 for 3 cycles during LOAD_STALL → MEM_WAIT for 3 cycles with all *_ld=0, memwb_bubble=1; on ready, the stall completes and returns to RUN; stall_cnt=5 from zero.
- branch_taken with no hazard → ifid_clr=1 for one cycle, flush_cnt=1; branch_taken together with ldEX → stall only, flush_cnt unchanged.
- Drive reset low in MEM_WAIT → state=00 and outputs at reset values asynchronously; counters preloaded to 0xFFFF stay saturated under stalls until perf_clr=1, then read 0.
